// File: rtl/tinker_mem_responder.sv
// Tinker memory responder: unified byte store serving fetch and data ports.
// Single array access per cycle, fixed-latency in-order responses.
module tinker_mem_responder #(
    parameter int unsigned MEM_BYTES    = 524288,
    parameter int unsigned LATENCY      = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [63:0] if_req_addr,
    output logic        if_rsp_valid,
    output logic [31:0] if_rsp_data,
    output logic        if_rsp_err,
    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic        d_req_we,
    input  logic [63:0] d_req_addr,
    input  logic [63:0] d_req_wdata,
    output logic        d_rsp_valid,
    output logic [63:0] d_rsp_rdata,
    output logic        d_rsp_err
);

    localparam int unsigned AW = $clog2(MEM_BYTES);
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [63:0] MEM_TOP = 64'(MEM_BYTES);
    localparam logic [63:0] LIM_IF  = 64'(MEM_BYTES - 4);
    localparam logic [63:0] LIM_D   = 64'(MEM_BYTES - 8);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [7:0]    r_mem [MEM_BYTES];
    logic [SW-1:0] r_starve;

    // Response pipeline: stage 0 is loaded at the acceptance edge
    logic          r_pv [LATENCY];
    logic          r_pp [LATENCY];
    logic          r_pe [LATENCY];
    logic [63:0]   r_pd [LATENCY];

    logic          w_force_if;
    logic          w_grant_d;
    logic          w_grant_if;
    logic          w_any;
    logic          w_store;
    logic [63:0]   w_addr;
    logic          w_inrange;
    logic [63:0]   w_rd;
    logic [63:0]   w_s0_data;

    assign w_force_if   = if_req_valid && (r_starve == STARVE_MAX);
    assign d_req_ready  = !w_force_if;
    assign if_req_ready = !d_req_valid || w_force_if;
    assign w_grant_d    = d_req_valid && d_req_ready;
    assign w_grant_if   = if_req_valid && if_req_ready;
    assign w_any        = w_grant_d || w_grant_if;
    assign w_store      = w_grant_d && d_req_we;
    assign w_addr       = w_grant_d ? d_req_addr : if_req_addr;
    assign w_inrange    = w_grant_d ? (d_req_addr <= LIM_D)
                                    : (if_req_addr <= LIM_IF);

    // Gather up to 8 bytes at the granted address; bytes past the top read 0
    always_comb begin
        w_rd = '0;
        for (int i = 0; i < 8; i++) begin
            if (w_addr + 64'(i) < MEM_TOP) begin
                w_rd[8*i +: 8] = r_mem[w_addr[AW-1:0] + AW'(i)];
            end
        end
    end

    // Data entering the response pipeline: zero for stores, errors, idle
    always_comb begin
        w_s0_data = '0;
        if (w_any && w_inrange && !w_store) begin
            w_s0_data = w_grant_d ? w_rd : {32'h0, w_rd[31:0]};
        end
    end

    // Commit in-range stores at the acceptance edge
    always_ff @(posedge clk) begin
        if (w_store && w_inrange) begin
            for (int i = 0; i < 8; i++) begin
                r_mem[d_req_addr[AW-1:0] + AW'(i)] <= d_req_wdata[8*i +: 8];
            end
        end
    end

    // Starvation counter: counts data grants that bypass a waiting fetch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve <= '0;
        end else if (w_grant_if || !if_req_valid) begin
            r_starve <= '0;
        end else if (w_grant_d && r_starve != STARVE_MAX) begin
            r_starve <= r_starve + 1'b1;
        end
    end

    // Shift responses toward the output, one stage per cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(LATENCY); i++) begin
                r_pv[i] <= 1'b0;
                r_pp[i] <= 1'b0;
                r_pe[i] <= 1'b0;
                r_pd[i] <= '0;
            end
        end else begin
            r_pv[0] <= w_any;
            r_pp[0] <= w_grant_d;
            r_pe[0] <= w_any && !w_inrange;
            r_pd[0] <= w_s0_data;
            for (int i = 1; i < int'(LATENCY); i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pp[i] <= r_pp[i-1];
                r_pe[i] <= r_pe[i-1];
                r_pd[i] <= r_pd[i-1];
            end
        end
    end

    assign if_rsp_valid = r_pv[LATENCY-1] && !r_pp[LATENCY-1];
    assign if_rsp_err   = if_rsp_valid && r_pe[LATENCY-1];
    assign if_rsp_data  = if_rsp_valid ? r_pd[LATENCY-1][31:0] : 32'h0;
    assign d_rsp_valid  = r_pv[LATENCY-1] && r_pp[LATENCY-1];
    assign d_rsp_err    = d_rsp_valid && r_pe[LATENCY-1];
    assign d_rsp_rdata  = d_rsp_valid ? r_pd[LATENCY-1] : 64'h0;

endmodule

// File: tb/tb_tinker_mem_responder.sv
// Directed and model-checked bench for tinker_mem_responder.
// Main instance at LATENCY=2, side instances at LATENCY=1 and 5.
module tb_tinker_mem_responder;

    localparam int unsigned MB = 524288;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req_valid;
    logic [63:0] if_req_addr;
    logic        d_req_valid;
    logic        d_req_we;
    logic [63:0] d_req_addr;
    logic [63:0] d_req_wdata;

    logic        if_req_ready, d_req_ready;
    logic        if_rsp_valid, if_rsp_err, d_rsp_valid, d_rsp_err;
    logic [31:0] if_rsp_data;
    logic [63:0] d_rsp_rdata;

    logic        a_ifr, a_dr, a_ifv, a_ife, a_dv, a_de;
    logic [31:0] a_ifd;
    logic [63:0] a_dd;
    logic        b_ifr, b_dr, b_ifv, b_ife, b_dv, b_de;
    logic [31:0] b_ifd;
    logic [63:0] b_dd;

    int errors = 0;
    int checks = 0;

    logic [7:0] mm [logic [63:0]];

    always #5 clk = ~clk;

    tinker_mem_responder #(.MEM_BYTES(MB), .LATENCY(2), .STARVE_LIMIT(4)) u_dut (
        .clk(clk), .reset(reset),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready),
        .if_req_addr(if_req_addr), .if_rsp_valid(if_rsp_valid),
        .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready),
        .d_req_we(d_req_we), .d_req_addr(d_req_addr),
        .d_req_wdata(d_req_wdata), .d_rsp_valid(d_rsp_valid),
        .d_rsp_rdata(d_rsp_rdata), .d_rsp_err(d_rsp_err)
    );

    tinker_mem_responder #(.MEM_BYTES(MB), .LATENCY(1), .STARVE_LIMIT(4)) u_l1 (
        .clk(clk), .reset(reset),
        .if_req_valid(if_req_valid), .if_req_ready(a_ifr),
        .if_req_addr(if_req_addr), .if_rsp_valid(a_ifv),
        .if_rsp_data(a_ifd), .if_rsp_err(a_ife),
        .d_req_valid(d_req_valid), .d_req_ready(a_dr),
        .d_req_we(d_req_we), .d_req_addr(d_req_addr),
        .d_req_wdata(d_req_wdata), .d_rsp_valid(a_dv),
        .d_rsp_rdata(a_dd), .d_rsp_err(a_de)
    );

    tinker_mem_responder #(.MEM_BYTES(MB), .LATENCY(5), .STARVE_LIMIT(4)) u_l5 (
        .clk(clk), .reset(reset),
        .if_req_valid(if_req_valid), .if_req_ready(b_ifr),
        .if_req_addr(if_req_addr), .if_rsp_valid(b_ifv),
        .if_rsp_data(b_ifd), .if_rsp_err(b_ife),
        .d_req_valid(d_req_valid), .d_req_ready(b_dr),
        .d_req_we(d_req_we), .d_req_addr(d_req_addr),
        .d_req_wdata(d_req_wdata), .d_rsp_valid(b_dv),
        .d_rsp_rdata(b_dd), .d_rsp_err(b_de)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_req_valid = 1'b0;
        d_req_valid  = 1'b0;
        d_req_we     = 1'b0;
    endtask

    task automatic fetch(input logic [63:0] a);
        d_req_valid  = 1'b0;
        if_req_valid = 1'b1;
        if_req_addr  = a;
    endtask

    task automatic dreq(input logic we, input logic [63:0] a,
                        input logic [63:0] wd);
        if_req_valid = 1'b0;
        d_req_valid  = 1'b1;
        d_req_we     = we;
        d_req_addr   = a;
        d_req_wdata  = wd;
    endtask

    function automatic logic [63:0] mrd(input logic [63:0] a, input int n);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[8*i +: 8] = mm[a + 64'(i)];
        return r;
    endfunction

    // Random-phase model state
    logic        m_v [2];
    logic        m_p [2];
    logic        m_e [2];
    logic [63:0] m_d [2];
    int          mcnt;

    initial begin
        logic        ifv, dv, we, frc, gi, gd, nv, np, ne;
        logic [63:0] ia, da, wd, na, nd;
        int          n;

        reset = 1'b1;
        if_req_addr = '0;
        d_req_addr  = '0;
        d_req_wdata = '0;
        idle();

        u_dut.r_mem[32'h2000] = 8'h78; u_dut.r_mem[32'h2001] = 8'h56;
        u_dut.r_mem[32'h2002] = 8'h34; u_dut.r_mem[32'h2003] = 8'h12;
        u_l1.r_mem[32'h2000]  = 8'h78; u_l1.r_mem[32'h2001]  = 8'h56;
        u_l1.r_mem[32'h2002]  = 8'h34; u_l1.r_mem[32'h2003]  = 8'h12;
        u_l5.r_mem[32'h2000]  = 8'h78; u_l5.r_mem[32'h2001]  = 8'h56;
        u_l5.r_mem[32'h2002]  = 8'h34; u_l5.r_mem[32'h2003]  = 8'h12;
        for (int i = 0; i < 16; i++) u_dut.r_mem[32'h100 + i] = 8'h00;
        for (int i = 0; i < 8; i++)
            u_dut.r_mem[MB - 8 + i] = 8'(8'h11 * (i + 1));
        for (int i = 0; i < 256; i++) begin
            mm[64'h3000 + 64'(i)] = 8'($urandom);
            u_dut.r_mem[32'h3000 + i] = mm[64'h3000 + 64'(i)];
        end

        repeat (3) tick();
        chk("rst_if_valid", if_rsp_valid, 0);
        chk("rst_d_valid", d_rsp_valid, 0);
        chk("rst_d_rdata", d_rsp_rdata, 0);
        chk("rst_if_data", if_rsp_data, 0);
        chk("rst_errs", {if_rsp_err, d_rsp_err}, 0);
        reset = 1'b0;
        tick();

        // Fetch with latencies 1, 2, 5
        fetch(64'h2000);
        #1 chk("fetch_ready", if_req_ready, 1);
        tick();
        idle();
        chk("l1_if_valid", a_ifv, 1);
        chk("l1_if_data", a_ifd, 32'h12345678);
        chk("l2_if_early", if_rsp_valid, 0);
        tick();
        chk("l2_if_valid", if_rsp_valid, 1);
        chk("l2_if_data", if_rsp_data, 32'h12345678);
        chk("l2_if_err", if_rsp_err, 0);
        chk("l1_if_once", a_ifv, 0);
        tick();
        chk("l2_if_once", if_rsp_valid, 0);
        tick();
        chk("l5_if_early", b_ifv, 0);
        tick();
        chk("l5_if_valid", b_ifv, 1);
        chk("l5_if_data", b_ifd, 32'h12345678);

        // Store then loads of the stored word
        dreq(1'b1, 64'h100, 64'h0123456789ABCDEF);
        #1 chk("store_ready", d_req_ready, 1);
        tick();
        dreq(1'b0, 64'h100, 64'h0);
        tick();
        chk("st_ack_valid", d_rsp_valid, 1);
        chk("st_ack_rdata", d_rsp_rdata, 0);
        chk("st_ack_err", d_rsp_err, 0);
        dreq(1'b0, 64'h104, 64'h0);
        tick();
        idle();
        chk("ld100_valid", d_rsp_valid, 1);
        chk("ld100_rdata", d_rsp_rdata, 64'h0123456789ABCDEF);
        tick();
        chk("ld104_rdata", d_rsp_rdata, 64'h0000000001234567);
        chk("ld104_if_quiet", if_rsp_valid, 0);
        tick();
        chk("ld_drain", d_rsp_valid, 0);

        // Top-of-array boundaries
        dreq(1'b0, 64'(MB - 7), 64'h0);
        tick();
        dreq(1'b1, 64'(MB - 4), 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        chk("ld_m7_err", d_rsp_err, 1);
        chk("ld_m7_rdata", d_rsp_rdata, 0);
        dreq(1'b0, 64'(MB - 8), 64'h0);
        tick();
        chk("st_m4_err", d_rsp_err, 1);
        fetch(64'(MB - 4));
        tick();
        chk("ld_m8_err", d_rsp_err, 0);
        chk("ld_m8_rdata", d_rsp_rdata, 64'h8877665544332211);
        fetch(64'(MB - 3));
        tick();
        chk("if_m4_err", if_rsp_err, 0);
        chk("if_m4_data", if_rsp_data, 32'h88776655);
        fetch(64'hFFFF_FFFF_FFFF_FFFE);
        tick();
        idle();
        chk("if_m3_err", if_rsp_err, 1);
        chk("if_m3_data", if_rsp_data, 0);
        tick();
        chk("if_wrap_valid", if_rsp_valid, 1);
        chk("if_wrap_err", if_rsp_err, 1);
        tick();

        // Starvation: D,D,D,D,IF repeating
        if_req_valid = 1'b1; if_req_addr = 64'h2000;
        d_req_valid  = 1'b1; d_req_we = 1'b0; d_req_addr = 64'h3000;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk($sformatf("starve_ifr%0d", i), if_req_ready, (i % 5) == 4);
            chk($sformatf("starve_dr%0d", i), d_req_ready, (i % 5) != 4);
            tick();
        end
        idle();
        repeat (3) tick();

        // Reset with loads in flight
        dreq(1'b1, 64'h500, 64'hCAFEF00DDEADBEEF);
        tick();
        idle();
        repeat (3) tick();
        dreq(1'b0, 64'h500, 64'h0);
        tick();
        dreq(1'b0, 64'h508, 64'h0);
        #1 reset = 1'b1;
        tick();
        chk("rst_mid_valid", d_rsp_valid, 0);
        idle();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("rst_post%0d", i), d_rsp_valid, 0);
        end
        dreq(1'b0, 64'h500, 64'h0);
        tick();
        idle();
        tick();
        chk("rst_keep_valid", d_rsp_valid, 1);
        chk("rst_keep_rdata", d_rsp_rdata, 64'hCAFEF00DDEADBEEF);
        repeat (2) tick();

        // Random mixed traffic against a byte model
        mcnt = 0;
        for (int k = 0; k < 2; k++) begin
            m_v[k] = 0; m_p[k] = 0; m_e[k] = 0; m_d[k] = '0;
        end
        for (int c = 0; c < 200; c++) begin
            ifv = ($urandom % 3) != 0;
            dv  = ($urandom % 3) != 0;
            we  = $urandom_range(0, 1);
            ia  = ($urandom % 16 == 0) ? 64'(MB - 2)
                                        : 64'h3000 + 64'($urandom % 240);
            da  = ($urandom % 16 == 0) ? 64'(MB - 5)
                                        : 64'h3000 + 64'($urandom % 240);
            wd  = {$urandom, $urandom};
            if_req_valid = ifv; if_req_addr = ia;
            d_req_valid  = dv;  d_req_we = we;
            d_req_addr   = da;  d_req_wdata = wd;
            #1;
            frc = ifv && (mcnt == 4);
            gd  = dv && !frc;
            gi  = ifv && (!dv || frc);
            chk("rnd_ifr", if_req_ready, !dv || frc);
            chk("rnd_dr", d_req_ready, !frc);
            nv = gi || gd;
            np = gd;
            na = gd ? da : ia;
            n  = gd ? 8 : 4;
            ne = nv && (na > 64'(MB - n));
            nd = '0;
            if (nv && !ne && !(gd && we)) nd = mrd(na, n);
            if (gd && we && !ne)
                for (int i = 0; i < 8; i++) mm[da + 64'(i)] = wd[8*i +: 8];
            if (gi || !ifv) mcnt = 0;
            else if (gd && mcnt != 4) mcnt++;
            tick();
            m_v[1] = m_v[0]; m_p[1] = m_p[0];
            m_e[1] = m_e[0]; m_d[1] = m_d[0];
            m_v[0] = nv; m_p[0] = np; m_e[0] = ne; m_d[0] = nd;
            chk("rnd_if_valid", if_rsp_valid, m_v[1] && !m_p[1]);
            chk("rnd_d_valid", d_rsp_valid, m_v[1] && m_p[1]);
            chk("rnd_if_err", if_rsp_err, m_v[1] && !m_p[1] && m_e[1]);
            chk("rnd_d_err", d_rsp_err, m_v[1] && m_p[1] && m_e[1]);
            chk("rnd_if_data", if_rsp_data,
                (m_v[1] && !m_p[1]) ? {32'h0, m_d[1][31:0]} : 64'h0);
            chk("rnd_d_rdata", d_rsp_rdata,
                (m_v[1] && m_p[1]) ? m_d[1] : 64'h0);
        end
        idle();
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
